// File: rtl/lsu_mem_bridge.sv
// Load/store bridge between the RV32 memory stage and a word-organised data RAM.
// Optional response timeout in ISSUE/WAIT is enabled by defining LSU_TIMEOUT_EN.
module lsu_mem_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t      state_reg, state_next;
  logic        we_reg;
  logic [2:0]  funct3_reg;
  logic [1:0]  off_reg;
  logic [29:0] mem_addr_reg;
  logic [3:0]  mem_be_reg;
  logic [31:0] mem_wdata_reg;
  logic [31:0] rsp_rdata_reg;
  logic        rsp_err_reg;

  logic        req_illegal;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [31:0] shifted;
  logic [31:0] load_data;
  logic        timeout;

  // Width/alignment legality of the incoming request
  always_comb begin
    req_illegal = 1'b1;
    case (req_funct3)
      3'b000:  req_illegal = 1'b0;
      3'b100:  req_illegal = req_we;
      3'b001:  req_illegal = req_addr[0];
      3'b101:  req_illegal = req_we | req_addr[0];
      3'b010:  req_illegal = |req_addr[1:0];
      default: req_illegal = 1'b1;
    endcase
  end

  always_comb begin
    be_next    = 4'b1111;
    wdata_next = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        be_next    = 4'b0001 << req_addr[1:0];
        wdata_next = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be_next    = 4'b0011 << req_addr[1:0];
        wdata_next = {2{req_wdata[15:0]}};
      end
      default: begin
        be_next    = 4'b1111;
        wdata_next = req_wdata;
      end
    endcase
  end

  assign shifted = mem_rdata >> {off_reg, 3'b000};

  always_comb begin
    load_data = mem_rdata;
    case (funct3_reg)
      3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  load_data = {24'd0, shifted[7:0]};
      3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  load_data = {16'd0, shifted[15:0]};
      default: load_data = mem_rdata;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_reg;

  // Counter restarts whenever ISSUE or WAIT is (re)entered
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_reg <= '0;
    else if ((state_reg == ISSUE || state_reg == WAIT) && state_next == state_reg)
      cnt_reg <= cnt_reg + 1'b1;
    else
      cnt_reg <= '0;
  end

  assign timeout = (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:
        if (req_valid)
          state_next = req_illegal ? RESP : ISSUE;
      ISSUE:
        if (mem_gnt)
          state_next = we_reg ? RESP : WAIT;
        else if (timeout)
          state_next = RESP;
      WAIT:
        if (mem_rvalid || timeout)
          state_next = RESP;
      RESP:
        state_next = IDLE;
      default:
        state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    rsp_valid = 1'b0;
    case (state_reg)
      IDLE:  req_ready = 1'b1;
      ISSUE: begin
        mem_req = 1'b1;
        mem_we  = we_reg;
      end
      RESP:  rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Request capture and response data; response fields hold until the next RESP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_reg        <= 1'b0;
      funct3_reg    <= 3'd0;
      off_reg       <= 2'd0;
      mem_addr_reg  <= 30'd0;
      mem_be_reg    <= 4'd0;
      mem_wdata_reg <= 32'd0;
      rsp_rdata_reg <= 32'd0;
      rsp_err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE:
          if (req_valid) begin
            we_reg        <= req_we;
            funct3_reg    <= req_funct3;
            off_reg       <= req_addr[1:0];
            mem_addr_reg  <= req_addr[31:2];
            mem_be_reg    <= be_next;
            mem_wdata_reg <= wdata_next;
            if (req_illegal) begin
              rsp_err_reg   <= 1'b1;
              rsp_rdata_reg <= 32'd0;
            end
          end
        ISSUE:
          if (mem_gnt) begin
            if (we_reg) begin
              rsp_err_reg   <= 1'b0;
              rsp_rdata_reg <= 32'd0;
            end
          end else if (timeout) begin
            rsp_err_reg   <= 1'b1;
            rsp_rdata_reg <= 32'd0;
          end
        WAIT:
          if (mem_rvalid) begin
            rsp_err_reg   <= 1'b0;
            rsp_rdata_reg <= load_data;
          end else if (timeout) begin
            rsp_err_reg   <= 1'b1;
            rsp_rdata_reg <= 32'd0;
          end
        default: ;
      endcase
    end
  end

  assign mem_addr  = mem_addr_reg;
  assign mem_be    = mem_be_reg;
  assign mem_wdata = mem_wdata_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_lsu_mem_bridge.sv
// Directed plus randomized bench for lsu_mem_bridge against an arithmetic reference model.
module tb_lsu_mem_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_req;
  logic        mem_gnt;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int errors = 0;
  int checks = 0;
  logic [2:0] legal_codes [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

  lsu_mem_bridge #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic bit model_legal(input logic we, input logic [2:0] f3, input logic [31:0] a);
    if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) return 1'b0;
    if (we && (f3 == 3'b100 || f3 == 3'b101)) return 1'b0;
    if ((f3 == 3'b001 || f3 == 3'b101) && a[0]) return 1'b0;
    if (f3 == 3'b010 && a[1:0] != 2'b00) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
    int bytes;
    bytes = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    if (bytes == 4) return 4'hF;
    return 4'(((1 << bytes) - 1) << a[1:0]);
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
    if (f3[1:0] == 2'b00) return 32'(wd[7:0]) * 32'h01010101;
    if (f3[1:0] == 2'b01) return 32'(wd[15:0]) * 32'h00010001;
    return wd;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] sh;
    int v;
    sh = rd >> (8 * int'(a[1:0]));
    case (f3)
      3'b000: begin v = int'(sh[7:0]); if (v > 127) v -= 256; end
      3'b100: v = int'(sh[7:0]);
      3'b001: begin v = int'(sh[15:0]); if (v > 32767) v -= 65536; end
      3'b101: v = int'(sh[15:0]);
      default: v = int'(rd);
    endcase
    return 32'(v);
  endfunction

  task automatic run_txn(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input int gnt_wait, input int rv_wait, input logic [31:0] rdata);
    bit          ok;
    logic        exp_err;
    logic [31:0] exp_rd;
    ok = model_legal(we, f3, addr);
    chk({tag, ".ready_idle"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    if (!ok) begin
      exp_err = 1'b1; exp_rd = 32'd0;
    end else begin
      for (int i = 0; i <= gnt_wait; i++) begin
        chk({tag, ".issue_req"}, 32'(mem_req), 32'd1);
        chk({tag, ".issue_we"}, 32'(mem_we), 32'(we));
        chk({tag, ".issue_addr"}, 32'(mem_addr), 32'(addr[31:2]));
        chk({tag, ".issue_be"}, 32'(mem_be), 32'(model_be(f3, addr)));
        chk({tag, ".issue_ready"}, 32'(req_ready), 32'd0);
        chk({tag, ".issue_rsp"}, 32'(rsp_valid), 32'd0);
        if (we) chk({tag, ".issue_wdata"}, mem_wdata, model_wdata(f3, wd));
        mem_gnt = (i == gnt_wait);
        mem_rvalid = 1'($urandom);
        mem_rdata = $urandom;
        @(posedge clk); #1;
      end
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      if (we) begin
        exp_err = 1'b0; exp_rd = 32'd0;
      end else begin
        for (int j = 0; j <= rv_wait; j++) begin
          chk({tag, ".wait_req"}, 32'(mem_req), 32'd0);
          chk({tag, ".wait_rsp"}, 32'(rsp_valid), 32'd0);
          mem_rvalid = (j == rv_wait);
          mem_rdata = (j == rv_wait) ? rdata : $urandom;
          mem_gnt = 1'($urandom);
          @(posedge clk); #1;
        end
        mem_rvalid = 1'b0; mem_gnt = 1'b0;
        exp_err = 1'b0; exp_rd = model_load(f3, addr, rdata);
      end
    end
    chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, ".rsp_err"}, 32'(rsp_err), 32'(exp_err));
    chk({tag, ".rsp_rdata"}, rsp_rdata, exp_rd);
    chk({tag, ".rsp_memreq"}, 32'(mem_req), 32'd0);
    @(posedge clk); #1;
    chk({tag, ".post_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, ".post_err_hold"}, 32'(rsp_err), 32'(exp_err));
    chk({tag, ".post_rdata_hold"}, rsp_rdata, exp_rd);
    chk({tag, ".post_ready"}, 32'(req_ready), 32'd1);
    $display("txn %s we=%0d f3=%03b addr=%08h rdata=%08h err=%0d", tag, we, f3, addr, rsp_rdata, rsp_err);
  endtask

  initial begin
    logic        r_we;
    logic [2:0]  r_f3;
    logic [31:0] r_addr;

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0;
    req_wdata = 32'd0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
    #1;
    chk("reset.ready", 32'(req_ready), 32'd1);
    chk("reset.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset.rsp_err", 32'(rsp_err), 32'd0);
    chk("reset.rsp_rdata", rsp_rdata, 32'd0);
    chk("reset.mem_req", 32'(mem_req), 32'd0);
    chk("reset.mem_we", 32'(mem_we), 32'd0);
    chk("reset.mem_addr", 32'(mem_addr), 32'd0);
    chk("reset.mem_be", 32'(mem_be), 32'd0);
    chk("reset.mem_wdata", mem_wdata, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;

    run_txn("sb_0x103", 1'b1, 3'b000, 32'h0000_0103, 32'h0000_00A5, 0, 0, 32'd0);
    run_txn("lb_0x102", 1'b0, 3'b000, 32'h0000_0102, 32'd0, 0, 0, 32'h12F0_3456);
    run_txn("lbu_0x102", 1'b0, 3'b100, 32'h0000_0102, 32'd0, 0, 0, 32'h12F0_3456);
    run_txn("lh_misaligned", 1'b0, 3'b001, 32'h0000_0101, 32'd0, 0, 0, 32'd0);
    run_txn("lw_gnt_late", 1'b0, 3'b010, 32'h0000_0200, 32'd0, 3, 0, 32'hDEAD_BEEF);
    run_txn("sh_hi", 1'b1, 3'b001, 32'h0000_0012, 32'hCAFE_8001, 1, 0, 32'd0);
    run_txn("lhu_hi", 1'b0, 3'b101, 32'h0000_0012, 32'd0, 0, 2, 32'h8001_7FFF);
    run_txn("sbu_illegal", 1'b1, 3'b100, 32'h0000_0010, 32'h1234_5678, 0, 0, 32'd0);
    run_txn("f3_011", 1'b0, 3'b011, 32'h0000_0020, 32'd0, 0, 0, 32'd0);

    // Reset while in ISSUE: mem_req must fall without waiting for a clock edge
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0000_0300;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rst_issue.pre_req", 32'(mem_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_issue.mem_req", 32'(mem_req), 32'd0);
    chk("rst_issue.ready", 32'(req_ready), 32'd1);
    chk("rst_issue.mem_be", 32'(mem_be), 32'd0);
    chk("rst_issue.rsp_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Reset while in WAIT, then a stray mem_rvalid after release
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0000_0304;
    @(posedge clk); #1;
    req_valid = 1'b0; mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    chk("rst_wait.in_wait", 32'({req_ready, mem_req, rsp_valid}), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("rst_wait.mem_req", 32'(mem_req), 32'd0);
    chk("rst_wait.rsp_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("rst_wait.stray_rsp", 32'(rsp_valid), 32'd0);
      chk("rst_wait.stray_ready", 32'(req_ready), 32'd1);
      chk("rst_wait.stray_rdata", rsp_rdata, 32'd0);
    end
    mem_rvalid = 1'b0;

`ifdef LSU_TIMEOUT_EN
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0000_0400;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk("timeout.issue_req", 32'(mem_req), 32'd1);
      @(posedge clk); #1;
    end
    chk("timeout.mem_req_drop", 32'(mem_req), 32'd0);
    chk("timeout.rsp_valid", 32'(rsp_valid), 32'd1);
    chk("timeout.rsp_err", 32'(rsp_err), 32'd1);
    chk("timeout.rsp_rdata", rsp_rdata, 32'd0);
    @(posedge clk); #1;
    chk("timeout.ready", 32'(req_ready), 32'd1);
`endif

    for (int n = 0; n < 150; n++) begin
      r_we = 1'($urandom);
      r_f3 = 3'($urandom);
      if ($urandom_range(0, 3) != 0) r_f3 = legal_codes[$urandom_range(0, 4)];
      r_addr = $urandom;
      run_txn($sformatf("rnd%0d", n), r_we, r_f3, r_addr, $urandom,
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lsu_mem_bridge.md
Name: lsu_mem_bridge

Overview:
- Load/store unit between the RV32 core's memory-access stage and the word-organised data RAM.
- Takes one byte/half/word request at a time. For stores, generates the word address, byte enables and lane-replicated write data. For loads, extracts and sign/zero-extends the read data.
- Uses valid/ready handshakes on both sides. Stalls the core until the access completes.
- Detects misaligned and illegal accesses, which do not touch memory.

Parameters:
TIMEOUT_CYCLES, 255, cycles allowed in ISSUE or WAIT before an error response (used only with LSU_TIMEOUT_EN)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-high
req_valid  input  1  core presents a request
req_ready  output  1  LSU can accept; high only in IDLE
req_we  input  1  1 = store, 0 = load
req_funct3  input  3  RV32 width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
req_addr  input  32  byte address
req_wdata  input  32  store data, LSBs significant
rsp_valid  output  1  one-cycle completion pulse
rsp_rdata  output  32  extended load data; 0 for stores/errors
rsp_err  output  1  misaligned/illegal/timeout, valid with rsp_valid
mem_req  output  1  RAM access request
mem_gnt  input  1  RAM accepts the request this cycle
mem_we  output  1  RAM write
mem_addr  output  30  word address = req_addr[31:2]
mem_be  output  4  byte enables
mem_wdata  output  32  lane-replicated write data
mem_rvalid  input  1  read data valid
mem_rdata  input  32  read word

Behaviour:
- Reset is asynchronous and active-high. While rst is high:
  - state = IDLE;
  - rsp_valid, rsp_err, mem_req, mem_we = 0;
  - rsp_rdata, mem_addr, mem_be, mem_wdata = 0.
  - req_ready follows state (1 in IDLE).
- FSM: IDLE -> ISSUE -> (WAIT) -> RESP -> IDLE.
- IDLE, when req_valid = 1: latch we, funct3 and addr; compute be/wdata into registers.
  - Illegal conditions: funct3 in {011, 110, 111}; store with funct3 100/101; H/HU with addr[0] = 1; W with addr[1:0] != 0.
  - Illegal -> RESP with err = 1; mem_req never asserted.
  - Legal -> ISSUE.
- ISSUE: mem_req = 1. mem_addr, mem_be, mem_we and mem_wdata stay stable until mem_gnt.
  - On mem_gnt, a store -> RESP with err = 0.
  - On mem_gnt, a load -> WAIT.
  - mem_req drops on the cycle after the grant.
- WAIT: on mem_rvalid, capture the extracted data -> RESP.
- RESP: rsp_valid = 1 for exactly one cycle, then -> IDLE. rsp_rdata and rsp_err hold until the next response.
- mem_gnt outside ISSUE and mem_rvalid outside WAIT are ignored.
- Byte enables:
  - B: 4'b0001 << addr[1:0]
  - H: 4'b0011 << addr[1:0]
  - W: 4'b1111
- Write data:
  - B: {4{wdata[7:0]}}
  - H: {2{wdata[15:0]}}
  - W: wdata
- Load extraction: shifted = mem_rdata >> (8 * addr[1:0]).
  - B: sign-extend shifted[7:0].
  - BU: zero-extend shifted[7:0].
  - H: sign-extend shifted[15:0].
  - HU: zero-extend shifted[15:0].
  - W: mem_rdata.
- Minimum latency, counting request acceptance as cycle 0:
  - store with immediate grant: rsp_valid in cycle 2;
  - load with immediate grant and rvalid one cycle later: rsp_valid in cycle 3;
  - illegal access: rsp_valid in cycle 1.
- Back-to-back: a new request is accepted the cycle after RESP.
- Reset mid-transaction: abort immediately; mem_req falls asynchronously; no rsp_valid is produced. A late mem_rvalid after reset release is ignored.

Optional Feature:
LSU_TIMEOUT_EN:
- Defined: a counter clears on entry to ISSUE and to WAIT and increments each cycle in those states. If it reaches TIMEOUT_CYCLES with no mem_gnt (ISSUE) or no mem_rvalid (WAIT): mem_req drops, then RESP with rsp_err = 1 and rsp_rdata = 0.
- Undefined: no counter; the LSU waits indefinitely.

Test Plan:
1. SB, addr 0x00000103, wdata 0x000000A5, gnt immediate -> mem_addr 0x40, mem_be 4'b1000, mem_wdata 0xA5A5A5A5, mem_we 1; rsp_valid cycle 2, rsp_err 0, rsp_rdata 0.
2. LB / LBU, addr 0x00000102, mem_rdata 0x12F03456 -> mem_be 4'b0100; LB rsp_rdata 0xFFFFFFF0; LBU rsp_rdata 0x000000F0.
3. LH, addr 0x00000101 -> rsp_valid cycle 1 with rsp_err 1; mem_req stays 0 throughout.
4. LW, addr 0x00000200, mem_gnt held low 3 cycles -> mem_req/mem_addr 0x80/mem_be 4'hF stable and req_ready 0 for all 4 ISSUE cycles; rdata 0xDEADBEEF -> rsp_rdata 0xDEADBEEF.
5. Reset asserted in WAIT -> mem_req 0 and no rsp_valid; req_ready 1 after release; stray mem_rvalid ignored.
6. LSU_TIMEOUT_EN, TIMEOUT_CYCLES 8, mem_gnt never asserted -> mem_req drops after 8 ISSUE cycles; rsp_valid with rsp_err 1, rsp_rdata 0.
